// File: rtl/vga_frame_src_pkg.sv
// Shared types and timing helpers for the VGA frame source
// and its timing generator.
package vga_frame_src_pkg;

    typedef enum logic [1:0] {
        MODE_FB  = 2'd0,
        MODE_BAR = 2'd1,
        MODE_CHK = 2'd2,
        MODE_ONE = 2'd3
    } mode_e;

    // Stage-1 bundle: decoded timing for the pixel being fetched
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic        eof;
        logic        img;
        mode_e       mode;
    } s1_t;

    function automatic int total(input int s, input int bp,
                                 input int a, input int fp);
        return s + bp + a + fp;
    endfunction

    function automatic int act_lo(input int s, input int bp);
        return s + bp;
    endfunction

    function automatic int act_hi(input int s, input int bp, input int a);
        return s + bp + a;
    endfunction

    // First x belonging to bar i: smallest x with x*8 >= i*active
    function automatic int bar_edge(input int i, input int active);
        return (i * active + 7) / 8;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA counters with combinational sync/DE/coord decode
// of the current counter state.
module vga_timing_gen
    import vga_frame_src_pkg::*;
#(
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        sof_o,
    output logic        first_o,
    output logic        last_o
);

    localparam logic [11:0] H_LAST = 12'(total(H_SYNC, H_BP, H_ACTIVE, H_FP) - 1);
    localparam logic [11:0] V_LAST = 12'(total(V_SYNC, V_BP, V_ACTIVE, V_FP) - 1);
    localparam logic [11:0] H_S1   = 12'(H_SYNC);
    localparam logic [11:0] V_S1   = 12'(V_SYNC);
    localparam logic [11:0] H_A0   = 12'(act_lo(H_SYNC, H_BP));
    localparam logic [11:0] V_A0   = 12'(act_lo(V_SYNC, V_BP));
    localparam logic [11:0] H_A1   = 12'(act_hi(H_SYNC, H_BP, H_ACTIVE));
    localparam logic [11:0] V_A1   = 12'(act_hi(V_SYNC, V_BP, V_ACTIVE));

    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic        hact, vact;

    always_comb begin
        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hact    = (hcnt_q >= H_A0) && (hcnt_q < H_A1);
    assign vact    = (vcnt_q >= V_A0) && (vcnt_q < V_A1);
    assign de_o    = hact && vact;
    assign hs_o    = (hcnt_q < H_S1) ? SYNC_POL : ~SYNC_POL;
    assign vs_o    = (vcnt_q < V_S1) ? SYNC_POL : ~SYNC_POL;
    assign x_o     = de_o ? hcnt_q - H_A0 : '0;
    assign y_o     = de_o ? vcnt_q - V_A0 : '0;
    assign sof_o   = (hcnt_q == H_A0) && (vcnt_q == V_A0);
    assign first_o = (hcnt_q == '0) && (vcnt_q == '0);
    assign last_o  = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

endmodule

// File: rtl/vga_frame_src.sv
// VGA-timed video source: frame-buffer replay or built-in patterns,
// three-stage pipeline so every output is registered and aligned.
module vga_frame_src
    import vga_frame_src_pkg::*;
#(
    parameter int   PIX_W    = 1,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   IMG_W    = 128,
    parameter int   IMG_H    = 128,
    parameter logic SYNC_POL = 1'b0,
    parameter logic [PIX_W-1:0] BG_VAL = '0,
    localparam int  DEPTH    = IMG_W * IMG_H,
    localparam int  AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             iCLK,
    input  logic             rst,
    input  logic [1:0]       iMode,
    input  logic             iWr_en,
    input  logic [AW-1:0]    iWr_addr,
    input  logic [PIX_W-1:0] iWr_data,
    output logic             oVGA_HS,
    output logic             oVGA_VS,
    output logic             oVGA_DE,
    output logic [PIX_W-1:0] oPix,
    output logic [11:0]      oCoord_X,
    output logic [11:0]      oCoord_Y,
    output logic             oFrame_start,
    output logic [15:0]      oFrame_cnt
);

    logic        hs0, vs0, de0, sof0, first0, last0, img0;
    logic [11:0] x0, y0;

    vga_timing_gen #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
        .SYNC_POL(SYNC_POL)
    ) u_tim (
        .clk_i(iCLK), .rst_i(rst),
        .hs_o(hs0), .vs_o(vs0), .de_o(de0),
        .x_o(x0), .y_o(y0),
        .sof_o(sof0), .first_o(first0), .last_o(last0)
    );

    mode_e         mode_q, mode_d;
    logic [AW-1:0] ptr_q, ptr_d;

    assign img0 = de0 && (x0 < 12'(IMG_W)) && (y0 < 12'(IMG_H));

    // Row-major pointer walks the image area, so no y*IMG_W multiply
    always_comb begin
        mode_d = mode_q;
        ptr_d  = ptr_q;
        if (first0) begin
            mode_d = mode_e'(iMode);
            ptr_d  = '0;
        end else if (img0) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (rst) begin
            mode_q <= MODE_FB;
            ptr_q  <= '0;
        end else begin
            mode_q <= mode_d;
            ptr_q  <= ptr_d;
        end
    end

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] rd_q;

    always_ff @(posedge iCLK) begin
        if (iWr_en && (32'(iWr_addr) < DEPTH))
            mem_q[iWr_addr] <= iWr_data;
        rd_q <= mem_q[ptr_q];
    end

    s1_t s1_d, s1_q;

    assign s1_d = '{hs: hs0, vs: vs0, de: de0, x: x0, y: y0,
                    sof: sof0, eof: last0, img: img0, mode: mode_q};

    always_ff @(posedge iCLK) begin
        if (rst) begin
            s1_q    <= '0;
            s1_q.hs <= ~SYNC_POL;
            s1_q.vs <= ~SYNC_POL;
        end else begin
            s1_q <= s1_d;
        end
    end

    logic [2:0]       bar;
    logic [PIX_W-1:0] pix_d;

    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++)
            if (s1_q.x >= 12'(bar_edge(i, H_ACTIVE)))
                bar = 3'(i);
    end

    always_comb begin
        pix_d = '0;
        if (s1_q.de) begin
            unique case (s1_q.mode)
                MODE_FB:  pix_d = s1_q.img ? rd_q : BG_VAL;
                MODE_BAR: pix_d = PIX_W'(bar);
                MODE_CHK: pix_d = {PIX_W{s1_q.x[3] ^ s1_q.y[3]}};
                MODE_ONE: pix_d = '1;
            endcase
        end
    end

    logic             hs_q, vs_q, de_q, sof_q;
    logic [11:0]      x_q, y_q;
    logic [PIX_W-1:0] pix_q;
    logic [15:0]      fcnt_q;

    always_ff @(posedge iCLK) begin
        if (rst) begin
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            de_q   <= 1'b0;
            sof_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            pix_q  <= '0;
            fcnt_q <= '0;
        end else begin
            hs_q   <= s1_q.hs;
            vs_q   <= s1_q.vs;
            de_q   <= s1_q.de;
            sof_q  <= s1_q.sof;
            x_q    <= s1_q.x;
            y_q    <= s1_q.y;
            pix_q  <= pix_d;
            fcnt_q <= fcnt_q + 16'(s1_q.eof);
        end
    end

    assign oVGA_HS      = hs_q;
    assign oVGA_VS      = vs_q;
    assign oVGA_DE      = de_q;
    assign oPix         = pix_q;
    assign oCoord_X     = x_q;
    assign oCoord_Y     = y_q;
    assign oFrame_start = sof_q;
    assign oFrame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_frame_src.sv
// Scoreboard bench for vga_frame_src on a tiny 14x7 raster with a
// 4x2 image, checked against a per-pixel reference model.
module tb_vga_frame_src;

    localparam int HS = 2, HB = 2, HA = 8, HF = 2;
    localparam int VS = 1, VB = 1, VA = 4, VF = 1;
    localparam int IW = 4, IH = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        we = 1'b0;
    logic [2:0]  wa = 3'd0;
    logic [0:0]  wd = 1'b0;
    logic        hs, vs, de, fs;
    logic [0:0]  pix;
    logic [11:0] cx, cy;
    logic [15:0] fcnt;

    vga_frame_src #(
        .PIX_W(1),
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .IMG_W(IW), .IMG_H(IH), .SYNC_POL(1'b0), .BG_VAL(1'b0)
    ) dut (
        .iCLK(clk), .rst(rst), .iMode(mode),
        .iWr_en(we), .iWr_addr(wa), .iWr_data(wd),
        .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_DE(de), .oPix(pix),
        .oCoord_X(cx), .oCoord_Y(cy),
        .oFrame_start(fs), .oFrame_cnt(fcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hs; bit vs; bit de; bit pix;
        int x; int y; bit fs; int fcnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mh = 0, mv = 0, mmode = 0, mfcnt = 0;
    int   curmode = 0;
    bit   frc = 1'b0;
    bit   fb[8];
    exp_t d1, eo;

    task automatic check(input string n, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", n, $time, act, exp);
        end
    endtask

    function automatic exp_t rst_val();
        exp_t e;
        e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.pix = 1'b0;
        e.x = 0; e.y = 0; e.fs = 1'b0; e.fcnt = 0;
        return e;
    endfunction

    function automatic bit ref_pix(input int x, input int y, input int md);
        case (md)
            0:       return (x < IW && y < IH) ? fb[y * IW + x] : 1'b0;
            1:       return 1'((x * 8 / HA) % 2);
            2:       return 1'(((x / 8) % 2) ^ ((y / 8) % 2));
            default: return 1'b1;
        endcase
    endfunction

    // Reference: expected output = raster position two clocks earlier
    task automatic model_edge();
        exp_t n;
        if (rst) begin
            mh = 0; mv = 0; mmode = 0; mfcnt = 0;
            d1 = rst_val();
            eo = rst_val();
        end else begin
            eo = d1;
            n.hs = (mh >= HS);
            n.vs = (mv >= VS);
            n.de = (mh >= HS + HB) && (mh < HS + HB + HA) &&
                   (mv >= VS + VB) && (mv < VS + VB + VA);
            n.x  = n.de ? mh - (HS + HB) : 0;
            n.y  = n.de ? mv - (VS + VB) : 0;
            n.fs = (mh == HS + HB) && (mv == VS + VB);
            if (mh == HT - 1 && mv == VT - 1)
                mfcnt = (mfcnt + 1) % 65536;
            n.fcnt = mfcnt;
            n.pix  = n.de ? ref_pix(n.x, n.y, mmode) : 1'b0;
            d1 = n;
            if (mh == 0 && mv == 0)
                mmode = int'(mode);
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
        if (we)
            fb[wa] = wd[0];
    endtask

    task automatic cyc1(input bit r, input int md, input bit w,
                        input int a, input bit d);
        rst  = r;
        mode = md[1:0];
        we   = w;
        wa   = a[2:0];
        wd   = d;
        @(posedge clk);
        #1;
        model_edge();
        if (frc) begin
            force dut.fcnt_q = 16'hFFFF;
            #1;
            release dut.fcnt_q;
            mfcnt   = 65535;
            d1.fcnt = 65535;
            eo.fcnt = 65535;
        end
        sb.push_back(eo);
    endtask

    task automatic run(input int n, input int md);
        curmode = md;
        repeat (n) cyc1(1'b0, md, 1'b0, 0, 1'b0);
    endtask

    task automatic wait_for(input int h, input int v);
        int k;
        k = 0;
        while (!(mh == h && mv == v) && k < 4 * HT * VT) begin
            cyc1(1'b0, curmode, 1'b0, 0, 1'b0);
            k++;
        end
        if (!(mh == h && mv == v)) begin
            errors++;
            $display("FAIL wait_for h=%0d v=%0d timed out", h, v);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("hs",   16'(hs),   16'(e.hs));
            check("vs",   16'(vs),   16'(e.vs));
            check("de",   16'(de),   16'(e.de));
            check("pix",  16'(pix),  16'(e.pix));
            check("x",    16'(cx),   16'(e.x));
            check("y",    16'(cy),   16'(e.y));
            check("fs",   16'(fs),   16'(e.fs));
            check("fcnt", fcnt,      16'(e.fcnt));
        end
    end

    initial begin
        for (int i = 0; i < 8; i++)
            cyc1(1'b1, 0, 1'b1, i, 1'b0);
        cyc1(1'b0, 0, 1'b1, 0, 1'b1);
        cyc1(1'b0, 0, 1'b1, 5, 1'b1);
        cyc1(1'b0, 0, 1'b1, 7, 1'b1);
        run(2 * HT * VT - 3, 0);

        wait_for(0, 3);
        run(2 * HT * VT, 2);
        run(2 * HT * VT, 3);
        run(HT * VT, 1);

        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(15) == 0)
                curmode = int'($urandom_range(3));
            cyc1(1'b0, curmode, ($urandom_range(3) == 0),
                 int'($urandom_range(7)), 1'($urandom_range(1)));
        end

        curmode = 0;
        run(HT * VT, 0);
        wait_for(7, 3);
        cyc1(1'b1, 0, 1'b0, 0, 1'b0);
        run(3 * HT * VT + 2, 0);
        @(negedge clk);
        check("fcnt_after3", fcnt, 16'd3);

        wait_for(5, 1);
        frc = 1'b1;
        cyc1(1'b0, 0, 1'b0, 0, 1'b0);
        frc = 1'b0;
        run(HT * VT + 4, 0);

        cyc1(1'b0, 0, 1'b1, 0, 1'b0);
        wait_for(4, 2);
        cyc1(1'b0, 0, 1'b1, 0, 1'b1);
        run(2 * HT * VT, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
